// File: rtl/spectrum_bar_processor.sv
// spectrum_bar_processor: turns 8-band magnitude frames into smoothed bar levels with peak-hold markers,
// processing one band per clock after a spectrum_valid strobe.
module spectrum_bar_processor #(
    parameter int LEVEL_SHIFT = 8,
    parameter int HOLD_FRAMES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [95:0] spectrum_in,
    input  logic        spectrum_valid,
    input  logic        clear,
    output logic [31:0] bar_levels,
    output logic [31:0] peak_levels,
    output logic        frame_done,
    output logic        busy,
    output logic        overrun
);
    typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

    state_t          r_state, w_next;
    logic [2:0]      r_idx;
    logic [95:0]     r_buf;
    logic [7:0][3:0] r_bar, r_peak;
    logic [7:0][7:0] r_hold;
    logic            r_overrun;
    logic [11:0]     w_band, w_shift;
    logic [3:0]      w_lvl, w_bar, w_peak, w_nb;
    logic [7:0]      w_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (clear)                                  w_next = IDLE;
        else if (r_state == IDLE && spectrum_valid) w_next = PROC;
        else if (r_state == PROC && r_idx == 3'd7)  w_next = DONE;
        else if (r_state == DONE)                   w_next = IDLE;
    end

    always_comb begin
        w_band  = r_buf[12*r_idx +: 12];
        w_shift = w_band >> LEVEL_SHIFT;
        w_lvl   = (w_shift > 12'd15) ? 4'hF : w_shift[3:0];
        w_bar   = r_bar[r_idx];
        w_peak  = r_peak[r_idx];
        w_hold  = r_hold[r_idx];
        // lvl < bar implies bar >= 1, so the decay can never wrap
        w_nb    = (w_lvl >= w_bar) ? w_lvl : w_bar - 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_buf     <= '0;
            r_bar     <= '0;
            r_peak    <= '0;
            r_hold    <= '0;
            r_overrun <= 1'b0;
        end else if (clear) begin
            r_idx     <= '0;
            r_bar     <= '0;
            r_peak    <= '0;
            r_hold    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (spectrum_valid && r_state == IDLE) begin
                r_buf <= spectrum_in;
                r_idx <= '0;
            end
            if (spectrum_valid && r_state != IDLE) r_overrun <= 1'b1;
            if (r_state == PROC) begin
                r_idx        <= r_idx + 3'd1;
                r_bar[r_idx] <= w_nb;
                // peak > nb whenever it is not overwritten, so peak-1 stays >= bar
                if (w_nb >= w_peak) begin
                    r_peak[r_idx] <= w_nb;
                    r_hold[r_idx] <= 8'(HOLD_FRAMES);
                end else if (w_hold != 8'd0) begin
                    r_hold[r_idx] <= w_hold - 8'd1;
                end else begin
                    r_peak[r_idx] <= w_peak - 4'd1;
                end
            end
        end
    end

    assign bar_levels  = r_bar;
    assign peak_levels = r_peak;
    assign frame_done  = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign overrun     = r_overrun;
endmodule

// File: tb/tb_spectrum_bar_processor.sv
// tb_spectrum_bar_processor: drives default and LEVEL_SHIFT=4 instances with directed and random frames,
// comparing against an integer reference model of the bar/peak rules.
module tb_spectrum_bar_processor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [95:0] spectrum_in = '0;
    logic        spectrum_valid = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] bar_a, peak_a, bar_b, peak_b;
    logic        fd_a, busy_a, ovr_a, fd_b, busy_b, ovr_b;

    int errors = 0;
    int checks = 0;

    int sh[2] = '{8, 4};
    int mb[2][8], mp[2][8], mh[2][8];
    int nb[2][8], np[2][8], nh[2][8];
    bit m_ovr;

    always #5 clk = ~clk;

    spectrum_bar_processor dut_a (
        .clk(clk), .rst_n(rst_n), .spectrum_in(spectrum_in), .spectrum_valid(spectrum_valid),
        .clear(clear), .bar_levels(bar_a), .peak_levels(peak_a), .frame_done(fd_a),
        .busy(busy_a), .overrun(ovr_a)
    );

    spectrum_bar_processor #(.LEVEL_SHIFT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .spectrum_in(spectrum_in), .spectrum_valid(spectrum_valid),
        .clear(clear), .bar_levels(bar_b), .peak_levels(peak_b), .frame_done(fd_b),
        .busy(busy_b), .overrun(ovr_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int band_of(input logic [95:0] d, input int k);
        logic [11:0] b;
        b = d[12*k +: 12];
        return int'(b);
    endfunction

    task automatic model_next(input logic [95:0] d);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 8; k++) begin
                int lvl;
                lvl = band_of(d, k) / (1 << sh[i]);
                if (lvl > 15) lvl = 15;
                nb[i][k] = (lvl >= mb[i][k]) ? lvl : mb[i][k] - 1;
                np[i][k] = mp[i][k];
                nh[i][k] = mh[i][k];
                if (nb[i][k] >= mp[i][k]) begin
                    np[i][k] = nb[i][k];
                    nh[i][k] = 16;
                end else if (mh[i][k] > 0) nh[i][k] = mh[i][k] - 1;
                else np[i][k] = mp[i][k] - 1;
            end
    endtask

    task automatic model_commit();
        mb = nb;
        mp = np;
        mh = nh;
    endtask

    task automatic model_zero();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 8; k++) begin
                mb[i][k] = 0;
                mp[i][k] = 0;
                mh[i][k] = 0;
            end
        m_ovr = 0;
    endtask

    // expected packed output with bands below e already updated
    function automatic logic [31:0] pk(input int i, input int e, input bit pkk);
        logic [31:0] r;
        int v;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < e) v = pkk ? np[i][k] : nb[i][k];
            else       v = pkk ? mp[i][k] : mb[i][k];
            r[4*k +: 4] = 4'(v);
        end
        return r;
    endfunction

    task automatic check_outputs(input string tag, input int e);
        check({tag, "_bar_a"}, bar_a, pk(0, e, 0));
        check({tag, "_peak_a"}, peak_a, pk(0, e, 1));
        check({tag, "_bar_b"}, bar_b, pk(1, e, 0));
        check({tag, "_peak_b"}, peak_b, pk(1, e, 1));
    endtask

    task automatic frame(input logic [95:0] d, input bit ovr);
        model_next(d);
        @(negedge clk);
        spectrum_in = d;
        spectrum_valid = 1'b1;
        @(negedge clk);
        spectrum_valid = 1'b0;
        spectrum_in = {$urandom, $urandom, $urandom};
        check("busy_e0", {busy_a, busy_b}, 2'b11);
        check("fd_e0", {fd_a, fd_b}, 2'b00);
        for (int e = 1; e <= 8; e++) begin
            if (ovr && e == 4) spectrum_valid = 1'b1;
            @(negedge clk);
            spectrum_valid = 1'b0;
            if (ovr && e == 4) m_ovr = 1;
            if (e == 1 || e == 4) check_outputs($sformatf("band_e%0d", e), e);
            if (e < 8) check("fd_low", {fd_a, fd_b}, 2'b00);
        end
        check("fd_e8", {fd_a, fd_b}, 2'b11);
        check("ovr", {ovr_a, ovr_b}, {m_ovr, m_ovr});
        check_outputs("frame", 8);
        model_commit();
        @(negedge clk);
        check("fd_e9", {fd_a, fd_b}, 2'b00);
        check("busy_e9", {busy_a, busy_b}, 2'b00);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        spectrum_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        spectrum_valid = 1'b0;
        model_zero();
        check("clr_ovr", {ovr_a, ovr_b}, 2'b00);
        check("clr_busy", {busy_a, busy_b}, 2'b00);
    endtask

    task automatic abort_frame(input bit use_rst, input logic [95:0] d);
        logic fd_seen;
        @(negedge clk);
        spectrum_in = d;
        spectrum_valid = 1'b1;
        @(negedge clk);
        spectrum_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (use_rst) begin
            rst_n = 1'b0;
            #1;
            check("rst_busy", {busy_a, busy_b}, 2'b00);
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            clear = 1'b1;
            spectrum_valid = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            spectrum_valid = 1'b0;
            check("clr_busy", {busy_a, busy_b}, 2'b00);
        end
        model_zero();
        check_outputs(use_rst ? "abort_rst" : "abort_clr", 0);
        check("abort_ovr", {ovr_a, ovr_b}, 2'b00);
        fd_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            fd_seen |= fd_a | fd_b;
        end
        check("abort_no_fd", fd_seen, 1'b0);
    endtask

    initial begin
        model_zero();
        #12;
        check("rst_out", {bar_a, peak_a}, 64'd0);
        check("rst_flags", {fd_a, busy_a, ovr_a, fd_b, busy_b, ovr_b}, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;

        frame({8{12'hA55}}, 0);
        check("attack_bar", bar_a, 32'hAAAAAAAA);
        check("attack_peak", peak_a, 32'hAAAAAAAA);
        for (int j = 0; j < 20; j++) begin
            frame('0, 0);
            repeat (2) @(negedge clk);
        end
        check("decay_bar", bar_a, 32'h0);
        check("decay_peak", peak_a, 32'h66666666);

        begin
            logic [95:0] d;
            for (int k = 0; k < 8; k++) d[12*k +: 12] = 12'((k + 1) << 8);
            frame(d, 0);
        end
        check("band_map", bar_a, 32'h87654321);

        frame({8{12'h3C0}}, 1);
        check("ovr_set", ovr_a, 1'b1);
        do_clear();
        check_outputs("after_clear", 0);

        frame({8{12'h0FF}}, 0);
        check("sat_b", bar_b, 32'hFFFFFFFF);
        check("sat_a", bar_a, 32'h0);

        for (int j = 0; j < 30; j++) begin
            frame({$urandom, $urandom, $urandom}, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 9) == 0) do_clear();
        end

        abort_frame(0, {8{12'hFFF}});
        abort_frame(1, {8{12'h777}});
        frame({$urandom, $urandom, $urandom}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spectrum_bar_processor.md
SPECTRUM_BAR_PROCESSOR -- requirements
Module: spectrum_bar_processor

Interface
REQ-001 SHALL have parameter LEVEL_SHIFT, default 8, right-shift applied to a 12-bit band magnitude to form a bar level.
REQ-002 SHALL have parameter HOLD_FRAMES, default 16, number of frames a peak marker is held before it begins to decay (legal 1..255).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 spectrum_in  input  96  packed band magnitudes; band k = bits [12k+11:12k], k=0..7.
REQ-006 spectrum_valid  input  1  one-cycle strobe marking spectrum_in valid.
REQ-007 clear  input  1  synchronous clear of bars, peaks, hold counters and overrun.
REQ-008 bar_levels  output  32  smoothed bar level per band, 4 bits each, band k = bits [4k+3:4k].
REQ-009 peak_levels  output  32  peak-hold marker per band, same packing.
REQ-010 frame_done  output  1  one-cycle pulse after all 8 bands of a frame are updated.
REQ-011 busy  output  1  high while a frame is being processed.
REQ-012 overrun  output  1  sticky flag: a spectrum_valid strobe was dropped.

Function
REQ-013 States SHALL be IDLE, PROC, DONE; busy = (state != IDLE).
REQ-014 In IDLE, spectrum_valid=1 at edge E0 SHALL capture spectrum_in into an internal 96-bit buffer, set band index to 0, enter PROC.
REQ-015 PROC SHALL process exactly one band per edge, band k at edge E(k+1); index increments 0..7; after band 7 (edge E8) go to DONE.
REQ-016 DONE SHALL last one cycle and return to IDLE at E9; frame_done SHALL be high exactly from E8 to E9.
REQ-017 Level: lvl = min(band >> LEVEL_SHIFT, 15), unsigned; with defaults lvl = band[11:8].
REQ-018 Bar update: if lvl >= bar[k] then bar[k] = lvl (instant attack); else bar[k] = bar[k] - 1 (decay one level per frame).
REQ-019 Peak update uses the new bar value nb: if nb >= peak[k] then peak[k] = nb and hold[k] = HOLD_FRAMES; else if hold[k] != 0 then hold[k] decrements, peak unchanged; else peak[k] decrements by 1.
REQ-020 peak[k] SHALL never be below bar[k] after any update; bar and peak SHALL never wrap below 0 or above 15.
REQ-021 bar_levels/peak_levels SHALL be registered and change only for band k at edge E(k+1); other bands hold.
REQ-022 spectrum_valid while state is PROC or DONE SHALL be ignored (buffer unchanged) and SHALL set overrun at the same edge.
REQ-023 clear=1 SHALL have priority over everything: at that edge zero all bars, peaks, hold counters, overrun, return to IDLE, abort any frame without frame_done; spectrum_valid in the same cycle SHALL be ignored and SHALL NOT set overrun.
REQ-024 Input latency: strobe at E0 -> band 0 visible after E1, band 7 visible after E8, frame_done high E8-E9, next strobe accepted at E9 or later.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, band index 0, capture buffer 0, all bar/peak/hold 0, frame_done 0, busy 0, overrun 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no frame_done; first strobe after release processes normally.

Verification
REQ-027 Attack: reset, one strobe with all bands 0xA55 -> after E8 every bar=0xA, peak=0xA, frame_done single pulse E8-E9, busy high E0-E9.
REQ-028 Decay/hold: after REQ-027 frame, 20 strobes of all-zero bands spaced 12 cycles -> bars 9,8,...,0 then stay 0; peaks hold 0xA for 16 frames (hold reaches 0), then decay 1 per frame but never below bar.
REQ-029 Band mapping: strobe with band k = (k+1)<<8 -> bar_levels = 0x87654321.
REQ-030 Overrun: strobe at E0 and again at E4 -> second ignored, overrun=1 from E4, outputs match first frame only; clear -> overrun 0.
REQ-031 Clear/reset mid-frame: clear at E3 -> all outputs 0, busy 0 next cycle, no frame_done; repeat with rst_n pulse -> same; LEVEL_SHIFT=4 with band 0x0FF -> lvl saturates to 15.
